// File: rtl/pe_stream_feeder.sv
// pe_stream_feeder
//   Upstream driver for a single mac_pe. Accepts a signed feature stream
//   (valid/ready, s_last closes a vector), forwards each beat to the PE,
//   flushes the PE pipeline with zero-valued valid beats, then snapshots the
//   PE's free-running accumulator and returns the per-vector dot product as
//   the difference from the previous snapshot. The PE is never cleared.
//
//   state  | meaning
//   IDLE   | waiting for first beat; weight writes accepted here only
//   STREAM | forwarding beats, bubbles when s_valid is low
//   FLUSH  | FLUSH_CYCLES zero-feature valid beats to drain the PE pipeline
//   SETTLE | SETTLE_CYCLES idle cycles, then snapshot accum_in
//   RESULT | holding result_data/result_valid until result_ready
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cfg_weight, cfg_weight_we      weight load (IDLE only)
//   s_feature/s_valid/s_last/s_ready  input feature stream
//   pe_weight/pe_feature/pe_valid  registered drive to mac_pe
//   accum_in                       mac_pe accumulator output
//   result_data/result_valid/result_ready  per-vector dot product
//   busy                           state is not IDLE
module pe_stream_feeder #(
  parameter int DATA_W        = 8,
  parameter int ACC_W         = 32,
  parameter int FLUSH_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] cfg_weight,
  input  logic              cfg_weight_we,
  input  logic [DATA_W-1:0] s_feature,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] pe_weight,
  output logic [DATA_W-1:0] pe_feature,
  output logic              pe_valid,
  input  logic [ACC_W-1:0]  accum_in,
  output logic [ACC_W-1:0]  result_data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_STREAM = 3'd1;
  localparam logic [2:0] ST_FLUSH  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_RESULT = 3'd4;

  localparam int CNT_MAX = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_pe_weight;
  logic [DATA_W-1:0] r_pe_feature;
  logic              r_pe_valid;
  logic [ACC_W-1:0]  r_result_data;
  logic              r_result_valid;
  logic [ACC_W-1:0]  r_base;

  logic w_ready;
  logic w_accept;

  assign w_ready  = (r_state == ST_IDLE) || (r_state == ST_STREAM);
  assign w_accept = s_valid & w_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_pe_weight    <= '0;
      r_pe_feature   <= '0;
      r_pe_valid     <= 1'b0;
      r_result_data  <= '0;
      r_result_valid <= 1'b0;
      r_base         <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_STREAM: begin
          if ((r_state == ST_IDLE) && cfg_weight_we) r_pe_weight <= cfg_weight;
          // no beat this cycle is a bubble: zero feature, not valid
          r_pe_valid   <= w_accept;
          r_pe_feature <= w_accept ? s_feature : '0;
          if (w_accept) begin
            if (s_last) begin
              r_state <= ST_FLUSH;
              r_cnt   <= FLUSH_LOAD;
            end else begin
              r_state <= ST_STREAM;
            end
          end
        end
        ST_FLUSH: begin
          r_pe_valid   <= 1'b1;
          r_pe_feature <= '0;
          if (r_cnt == '0) begin
            r_state <= ST_SETTLE;
            r_cnt   <= SETTLE_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_SETTLE: begin
          r_pe_valid   <= 1'b0;
          r_pe_feature <= '0;
          if (r_cnt == '0) begin
            // modular difference absorbs accumulator wrap
            r_result_data  <= accum_in - r_base;
            r_base         <= accum_in;
            r_result_valid <= 1'b1;
            r_state        <= ST_RESULT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESULT: begin
          r_pe_valid   <= 1'b0;
          r_pe_feature <= '0;
          if (result_ready) begin
            r_result_valid <= 1'b0;
            r_state        <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_pe_valid <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready      = w_ready;
  assign busy         = (r_state != ST_IDLE);
  assign pe_weight    = r_pe_weight;
  assign pe_feature   = r_pe_feature;
  assign pe_valid     = r_pe_valid;
  assign result_data  = r_result_data;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Testbench for pe_stream_feeder with a behavioural 3-stage mac_pe.
// Expected results come from a running sum of weight*feature over accepted
// beats and the last returned snapshot.
module tb_pe_stream_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cfg_weight;
  logic        cfg_weight_we;
  logic [7:0]  s_feature;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [7:0]  pe_weight;
  logic [7:0]  pe_feature;
  logic        pe_valid;
  logic [31:0] accum_in;
  logic [31:0] result_data;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  always #5 clk = ~clk;

  pe_stream_feeder #(.DATA_W(8), .ACC_W(32), .FLUSH_CYCLES(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .cfg_weight(cfg_weight), .cfg_weight_we(cfg_weight_we),
    .s_feature(s_feature), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .pe_weight(pe_weight), .pe_feature(pe_feature), .pe_valid(pe_valid),
    .accum_in(accum_in),
    .result_data(result_data), .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy)
  );

  // behavioural mac_pe: multiply, pipeline, accumulate (never reset)
  logic [31:0] p1, p2, pe_acc;
  logic        preload_req;
  logic [31:0] preload_val;
  always @(posedge clk) begin
    p1 <= pe_valid ? 32'(int'($signed(pe_weight)) * int'($signed(pe_feature))) : 32'd0;
    p2 <= p1;
    if (preload_req) pe_acc <= preload_val;
    else             pe_acc <= pe_acc + p2;
  end
  assign accum_in = pe_acc;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] ref_acc;
  logic [31:0] ref_base;
  logic [7:0]  ref_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // present one beat; caller is at posedge+1, returns at posedge+1 after acceptance
  task automatic beat(input logic [7:0] f, input bit last);
    s_feature = f;
    s_last    = last;
    s_valid   = 1'b1;
    @(negedge clk);
    chk("s_ready_beat", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0; s_feature = 8'd0; cfg_weight_we = 1'b0;
    ref_acc = ref_acc + 32'(int'($signed(ref_w)) * int'($signed(f)));
    chk("pe_valid_beat", {31'd0, pe_valid}, 32'd1);
    chk("pe_feature", {24'd0, pe_feature}, {24'd0, f});
    chk("pe_weight", {24'd0, pe_weight}, {24'd0, ref_w});
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("bubble_valid", {31'd0, pe_valid}, 32'd0);
      chk("bubble_feature", {24'd0, pe_feature}, 32'd0);
    end
  endtask

  task automatic flush_check();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("flush_valid", {31'd0, pe_valid}, 32'd1);
      chk("flush_feature", {24'd0, pe_feature}, 32'd0);
      chk("flush_sready", {31'd0, s_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk("settle_valid", {31'd0, pe_valid}, 32'd0);
  endtask

  task automatic take_result(input int delay);
    logic [31:0] exp;
    exp = ref_acc - ref_base;
    ref_base = ref_acc;
    for (int i = 0; i < 50 && result_valid !== 1'b1; i++) @(negedge clk);
    chk("res_valid", {31'd0, result_valid}, 32'd1);
    chk("res_data", result_data, exp);
    chk("res_sready", {31'd0, s_ready}, 32'd0);
    chk("res_busy", {31'd0, busy}, 32'd1);
    repeat (delay) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, result_valid}, 32'd1);
      chk("hold_data", result_data, exp);
      chk("hold_sready", {31'd0, s_ready}, 32'd0);
    end
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    chk("post_valid", {31'd0, result_valid}, 32'd0);
    chk("post_sready", {31'd0, s_ready}, 32'd1);
    chk("post_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic write_w(input logic [7:0] w);
    cfg_weight = w; cfg_weight_we = 1'b1;
    @(posedge clk);
    #1;
    cfg_weight_we = 1'b0;
    ref_w = w;
    chk("w_load", {24'd0, pe_weight}, {24'd0, w});
  endtask

  initial begin
    rst = 1'b1; cfg_weight = 8'd0; cfg_weight_we = 1'b0;
    s_feature = 8'd0; s_valid = 1'b0; s_last = 1'b0; result_ready = 1'b0;
    preload_req = 1'b1; preload_val = 32'd0;
    ref_acc = 32'd0; ref_base = 32'd0; ref_w = 8'd0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0; preload_req = 1'b0;
    chk("rst_pe_valid", {31'd0, pe_valid}, 32'd0);
    chk("rst_pe_weight", {24'd0, pe_weight}, 32'd0);
    chk("rst_pe_feature", {24'd0, pe_feature}, 32'd0);
    chk("rst_res_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_res_data", result_data, 32'd0);
    chk("rst_sready", {31'd0, s_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // pass 1: 5*(1+2+3) = 30
    write_w(8'd5);
    beat(8'd1, 0); beat(8'd2, 0); beat(8'd3, 1);
    flush_check();
    take_result(3);
    // pass 2: 5*(4-1) = 15
    beat(8'd4, 0); beat(8'hFF, 1);
    flush_check();
    take_result(0);
    // single-beat vector: -35
    beat(8'hF9, 1);
    chk("single_busy", {31'd0, busy}, 32'd1);
    flush_check();
    take_result(1);
    // gaps and backpressure
    beat(8'd6, 0); gap(2); beat(8'd2, 0); gap(1); beat(8'hFE, 1);
    flush_check();
    take_result(5);

    // weight write during STREAM is ignored
    beat(8'd3, 0);
    cfg_weight = 8'd9; cfg_weight_we = 1'b1;
    beat(8'd1, 0);
    cfg_weight = 8'd11; cfg_weight_we = 1'b1;
    beat(8'd2, 1);
    flush_check();
    take_result(0);

    // weight write and beat in the same IDLE cycle: new weight applies
    cfg_weight = 8'd7; cfg_weight_we = 1'b1; ref_w = 8'd7;
    beat(8'd2, 0); beat(8'd3, 1);
    flush_check();
    take_result(0);

    // wrap across 0x80000000: re-base near the edge, then true sum 40
    preload_req = 1'b1; preload_val = 32'h7FFF_FFF0;
    @(posedge clk);
    #1;
    preload_req = 1'b0; ref_acc = 32'h7FFF_FFF0;
    beat(8'd0, 1);
    flush_check();
    take_result(0);
    write_w(8'd4);
    beat(8'd3, 0); beat(8'd7, 1);
    flush_check();
    take_result(0);

    // randomized vectors
    for (int v = 0; v < 25; v++) begin
      int len;
      len = $urandom_range(1, 6);
      if ($urandom_range(0, 2) == 0) write_w(8'($urandom));
      else if ($urandom_range(0, 1) == 0) begin
        cfg_weight = 8'($urandom); cfg_weight_we = 1'b1; ref_w = cfg_weight;
      end
      for (int b = 0; b < len; b++) begin
        if (b > 0 && $urandom_range(0, 3) == 0) begin
          cfg_weight = 8'($urandom); cfg_weight_we = 1'b1;
        end
        beat(8'($urandom), b == len - 1);
        if (b < len - 1) gap($urandom_range(0, 2));
      end
      flush_check();
      take_result($urandom_range(0, 4));
    end

    // reset during FLUSH
    write_w(8'd5);
    beat(8'd2, 0); beat(8'd3, 1);
    @(posedge clk);
    #1;
    chk("pre_rst_flush", {31'd0, pe_valid}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst2_pe_valid", {31'd0, pe_valid}, 32'd0);
    chk("rst2_res_valid", {31'd0, result_valid}, 32'd0);
    chk("rst2_sready", {31'd0, s_ready}, 32'd1);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
    chk("rst2_weight", {24'd0, pe_weight}, 32'd0);
    ref_base = 32'd0; ref_w = 8'd0;
    repeat (6) @(posedge clk);
    #1;
    // base was cleared, so this result is the whole accumulator
    write_w(8'd3);
    beat(8'd1, 0); beat(8'd4, 1);
    flush_check();
    take_result(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pe_stream_feeder.md
Name: pe_stream_feeder

Overview:
- Upstream driver for one mac_pe.
- Accepts a signed int8 feature stream over a valid/ready handshake, with s_last marking the end of each dot-product vector.
- Presents each feature to the PE and automatically flushes the PE pipeline with zero-valued valid beats.
- Samples the PE's free-running accumulator and returns the per-vector dot product as the difference from the previous snapshot. The PE itself is never cleared.

Parameters:
- DATA_W, 8: feature and weight width, two's complement.
- ACC_W, 32: accumulator and result width.
- FLUSH_CYCLES, 4: zero-feature valid beats driven after the last beat of a vector. Must be at least PE pipeline depth + 1.
- SETTLE_CYCLES, 1: idle cycles after flush before accum_in is sampled.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cfg_weight  in  DATA_W  weight value to load
- cfg_weight_we  in  1  weight write strobe; honoured only in IDLE
- s_feature  in  DATA_W  input feature
- s_valid  in  1  input beat valid
- s_last  in  1  final beat of the vector
- s_ready  out  1  feeder can accept a beat
- pe_weight  out  DATA_W  to mac_pe.weight
- pe_feature  out  DATA_W  to mac_pe.feature_in
- pe_valid  out  1  to mac_pe.valid_in
- accum_in  in  ACC_W  from mac_pe.accum_out
- result_data  out  ACC_W  dot product of the last vector
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- busy  out  1  state is not IDLE

Behaviour:
- Reset values:
  - State IDLE.
  - pe_weight, pe_feature, pe_valid, result_data, result_valid = 0.
  - Base snapshot = 0.
  - s_ready = 1; busy = 0.
- Rst asserted in any state returns to the reset values on the next edge. Any partial vector and any pending result are discarded.
- All PE-side outputs are registered. A beat accepted (s_valid & s_ready) at edge N appears on pe_feature with pe_valid=1 during cycle N+1.
- IDLE:
  - s_ready=1.
  - cfg_weight_we loads pe_weight at the edge.
  - Accepting a beat with s_last=0 moves to STREAM.
  - Accepting a beat with s_last=1 moves to FLUSH.
  - If a weight write and a beat occur in the same cycle, the weight write wins and the beat is still accepted.
- STREAM:
  - s_ready=1; cfg_weight_we is ignored.
  - A cycle with no beat drives pe_valid=0, pe_feature=0 (a bubble).
  - Accepting a beat with s_last=1 moves to FLUSH.
- FLUSH:
  - s_ready=0.
  - Drives exactly FLUSH_CYCLES consecutive cycles of pe_valid=1, pe_feature=0, using a down-counter.
  - Then moves to SETTLE.
- SETTLE:
  - s_ready=0; pe_valid=0.
  - Waits SETTLE_CYCLES.
  - At the final SETTLE edge: result_data <= accum_in - base (modulo 2^ACC_W, no saturation), base <= accum_in, result_valid <= 1.
  - Moves to RESULT.
- RESULT:
  - s_ready=0.
  - result_data and result_valid hold stable until result_ready=1.
  - On the handshake edge, result_valid <= 0 and the state moves to IDLE.
  - s_ready becomes 1 in the following cycle, not combinationally.
- pe_weight is stable outside IDLE.
- Wrap of the PE accumulator is handled by the modular subtraction.

Test Plan:
- Pass 1, weight 5, with a behavioural 3-stage mac_pe model:
  - Stimulus: reset, cfg weight 5, beats 1, 2, 3 (s_last on 3).
  - Required: pe_feature sequence 1, 2, 3, then four valid zeros; result_data=30, result_valid held until result_ready.
- Pass 2, after pass 1:
  - Stimulus: beats 4, -1 (s_last).
  - Required: base 30, accum 45, result_data=15.
- Single-beat vector:
  - Stimulus: beat -7 with s_last, weight 5.
  - Required: IDLE→FLUSH directly; result_data=-35 (0xFFFFFFDD).
- Gaps and backpressure:
  - Stimulus: s_valid low for 2 cycles mid-vector; result_ready held low for 5 cycles.
  - Required: pe_valid=0 during the gaps; result value unchanged; s_ready=0 until one cycle after the result handshake.
- Weight gating and wrap:
  - Stimulus: cfg_weight_we during STREAM; then preload the model accum near 0x7FFFFFF0 and run a vector with true sum 40.
  - Required: pe_weight unchanged during STREAM; result_data=40.
- Reset mid-FLUSH:
  - Stimulus: assert rst during FLUSH.
  - Required: next cycle pe_valid=0, result_valid=0, s_ready=1, busy=0; base=0.
